// File: rtl/conv2_pingpong_ctrl.sv
// Ping-pong scheduler for the two conv2 activation BRAM banks (bank0 = *_a*, bank1 = *_b*).
// Define CONV2_PP_ERRCHK_EN to build the sticky protocol/range error flag.
module conv2_pingpong_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        bank_full,
  output logic              err,
  output logic              we_a1,
  output logic              we_a2,
  output logic [ADDR_W-1:0] addr_a1,
  output logic [ADDR_W-1:0] addr_a2,
  output logic [DATA_W-1:0] din_a1,
  output logic [DATA_W-1:0] din_a2,
  input  logic [DATA_W-1:0] dout_a1,
  input  logic [DATA_W-1:0] dout_a2,
  output logic              we_b1,
  output logic              we_b2,
  output logic [ADDR_W-1:0] addr_b1,
  output logic [ADDR_W-1:0] addr_b2,
  output logic [DATA_W-1:0] din_b1,
  output logic [DATA_W-1:0] din_b2,
  input  logic [DATA_W-1:0] dout_b1,
  input  logic [DATA_W-1:0] dout_b2
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("DEPTH exceeds the address space");
  end

  bank_st_e st_q [2];
  logic     wbank_q, rbank_q;
  logic     rv_p1_q, rsel_p1_q, rsel_q;
  logic     wr_acc, rd_acc, wr_go, rd_go;
  logic     unused_dout;

  // Port 1 is write-only and port 2 is never written, so these pins stay idle.
  assign unused_dout = ^{dout_a1, dout_b1};
  assign we_a2       = 1'b0;
  assign we_b2       = 1'b0;
  assign din_a2      = '0;
  assign din_b2      = '0;

  assign wr_ready  = (st_q[wbank_q] == StEmpty) || (st_q[wbank_q] == StFilling);
  assign rd_ready  = (st_q[rbank_q] == StFull) || (st_q[rbank_q] == StDraining);
  assign bank_full = {(st_q[1] == StFull) || (st_q[1] == StDraining),
                      (st_q[0] == StFull) || (st_q[0] == StDraining)};

  assign wr_acc = wr_req && wr_ready;
  assign rd_acc = rd_req && rd_ready;

`ifdef CONV2_PP_ERRCHK_EN
  localparam logic [ADDR_W:0] DepthLim = DEPTH[ADDR_W:0];

  logic wr_oob, rd_oob, err_q;

  assign wr_oob = {1'b0, wr_addr} >= DepthLim;
  assign rd_oob = {1'b0, rd_addr} >= DepthLim;
  // Out-of-range accepted requests still advance bank state but never reach the BRAM.
  assign wr_go  = wr_acc && !wr_oob;
  assign rd_go  = rd_acc && !rd_oob;
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((wr_req && (!wr_ready || wr_oob)) || (rd_req && (!rd_ready || rd_oob))) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wr_go = wr_acc;
  assign rd_go = rd_acc;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= StEmpty;
      st_q[1]   <= StEmpty;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      we_a1     <= 1'b0;
      we_b1     <= 1'b0;
      addr_a1   <= '0;
      addr_b1   <= '0;
      din_a1    <= '0;
      din_b1    <= '0;
      addr_a2   <= '0;
      addr_b2   <= '0;
      rv_p1_q   <= 1'b0;
      rsel_p1_q <= 1'b0;
      rd_valid  <= 1'b0;
      rsel_q    <= 1'b0;
    end else begin
      // Producer and consumer never own the same bank, so both updates can land together.
      if (wr_acc) st_q[wbank_q] <= wr_last ? StFull : StFilling;
      if (rd_acc) st_q[rbank_q] <= rd_last ? StEmpty : StDraining;
      wbank_q <= wbank_q ^ (wr_acc && wr_last);
      rbank_q <= rbank_q ^ (rd_acc && rd_last);

      we_a1 <= wr_go && !wbank_q;
      we_b1 <= wr_go && wbank_q;
      if (wr_go && !wbank_q) begin
        addr_a1 <= wr_addr;
        din_a1  <= wr_data;
      end
      if (wr_go && wbank_q) begin
        addr_b1 <= wr_addr;
        din_b1  <= wr_data;
      end

      if (rd_go && !rbank_q) addr_a2 <= rd_addr;
      if (rd_go && rbank_q)  addr_b2 <= rd_addr;
      rv_p1_q   <= rd_go;
      rsel_p1_q <= rbank_q;
      rd_valid  <= rv_p1_q;
      rsel_q    <= rsel_p1_q;
    end
  end

  // BRAM output lands one cycle after the address, aligned with rd_valid.
  assign rd_data = rd_valid ? (rsel_q ? dout_b2 : dout_a2) : '0;

endmodule

// File: tb/tb_conv2_pingpong_ctrl.sv
// Randomized bench for conv2_pingpong_ctrl against a frame-level reference model.
// Honours CONV2_PP_ERRCHK_EN the same way the design does.
module tb_conv2_pingpong_ctrl;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 1000;
  localparam int EMPTY = 0, FILLING = 1, FULL = 2, DRAINING = 3;

  logic clk, rst_n;
  logic wr_req, wr_last, rd_req, rd_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic wr_ready, rd_ready, rd_valid, err;
  logic [DW-1:0] rd_data;
  logic [1:0] bank_full;
  logic we_a1, we_a2, we_b1, we_b2;
  logic [AW-1:0] addr_a1, addr_a2, addr_b1, addr_b2;
  logic [DW-1:0] din_a1, din_a2, din_b1, din_b2;
  logic [DW-1:0] dout_a1, dout_a2, dout_b1, dout_b2;

  int checks, failures;

  conv2_pingpong_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .bank_full(bank_full), .err(err),
    .we_a1(we_a1), .we_a2(we_a2), .addr_a1(addr_a1), .addr_a2(addr_a2),
    .din_a1(din_a1), .din_a2(din_a2), .dout_a1(dout_a1), .dout_a2(dout_a2),
    .we_b1(we_b1), .we_b2(we_b2), .addr_b1(addr_b1), .addr_b2(addr_b2),
    .din_b1(din_b1), .din_b2(din_b2), .dout_b1(dout_b1), .dout_b2(dout_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two dual-port BRAM8K banks with 1-cycle read latency.
  logic [DW-1:0] bram_a [1024];
  logic [DW-1:0] bram_b [1024];
  always @(posedge clk) begin
    if (we_a1) bram_a[addr_a1] <= din_a1;
    if (we_a2) bram_a[addr_a2] <= din_a2;
    if (we_b1) bram_b[addr_b1] <= din_b1;
    if (we_b2) bram_b[addr_b2] <= din_b2;
    dout_a1 <= bram_a[addr_a1];
    dout_a2 <= bram_a[addr_a2];
    dout_b1 <= bram_b[addr_b1];
    dout_b2 <= bram_b[addr_b2];
  end

  // Reference model: bank status, pointers, bank contents and pending events.
  int            m_st [2];
  int            m_wb, m_rb;
  bit            m_err;
  logic [DW-1:0] m_mem   [2][1024];
  bit            m_known [2][1024];
  bit            e_wv;
  int            e_wb;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  bit            p1_v, p1_k, o_rv, o_k;
  logic [DW-1:0] p1_d, o_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st[0] = EMPTY;
    m_st[1] = EMPTY;
    m_wb = 0;
    m_rb = 0;
    m_err = 1'b0;
    e_wv = 1'b0;
    p1_v = 1'b0;
    o_rv = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_we", {60'd0, we_a1, we_a2, we_b1, we_b2}, 64'd0);
    check("rst_addr", {24'd0, addr_a1, addr_a2, addr_b1, addr_b2}, 64'd0);
    check("rst_din_a", din_a1 | din_a2, 64'd0);
    check("rst_din_b", din_b1 | din_b2, 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_ready", 64'(rd_ready), 64'd0);
    check("rst_bank_full", 64'(bank_full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
  endtask

  task automatic check_outputs();
    bit mw, mr;
    mw = (m_st[m_wb] == EMPTY) || (m_st[m_wb] == FILLING);
    mr = (m_st[m_rb] == FULL) || (m_st[m_rb] == DRAINING);
    check("wr_ready", 64'(wr_ready), 64'(mw));
    check("rd_ready", 64'(rd_ready), 64'(mr));
    check("bank_full", 64'(bank_full),
          64'({m_st[1] >= FULL, m_st[0] >= FULL}));
    check("err", 64'(err), 64'(m_err));
    check("we_a1", 64'(we_a1), 64'(e_wv && e_wb == 0));
    check("we_b1", 64'(we_b1), 64'(e_wv && e_wb == 1));
    check("we_x2", 64'({we_a2, we_b2}), 64'd0);
    if (e_wv && e_wb == 0) begin
      check("addr_a1", 64'(addr_a1), 64'(e_waddr));
      check("din_a1", din_a1, e_wdata);
    end
    if (e_wv && e_wb == 1) begin
      check("addr_b1", 64'(addr_b1), 64'(e_waddr));
      check("din_b1", din_b1, e_wdata);
    end
    check("rd_valid", 64'(rd_valid), 64'(o_rv));
    if (o_rv && o_k) check("rd_data", rd_data, o_d);
  endtask

  task automatic model_step();
    bit wacc, racc, w_ok, r_ok, mw, mr;
    mw = (m_st[m_wb] == EMPTY) || (m_st[m_wb] == FILLING);
    mr = (m_st[m_rb] == FULL) || (m_st[m_rb] == DRAINING);
    wacc = wr_req && mw;
    racc = rd_req && mr;
`ifdef CONV2_PP_ERRCHK_EN
    w_ok = wacc && (int'(wr_addr) < int'(DEPTH));
    r_ok = racc && (int'(rd_addr) < int'(DEPTH));
    if ((wr_req && (!mw || int'(wr_addr) >= int'(DEPTH))) ||
        (rd_req && (!mr || int'(rd_addr) >= int'(DEPTH)))) m_err = 1'b1;
`else
    w_ok = wacc;
    r_ok = racc;
`endif
    // The write pulse that was just observed commits at this edge.
    if (e_wv) begin
      m_mem[e_wb][e_waddr] = e_wdata;
      m_known[e_wb][e_waddr] = 1'b1;
    end
    e_wv = w_ok;
    e_wb = m_wb;
    e_waddr = wr_addr;
    e_wdata = wr_data;
    o_rv = p1_v;
    o_d  = p1_d;
    o_k  = p1_k;
    p1_v = r_ok;
    p1_d = m_mem[m_rb][rd_addr];
    p1_k = m_known[m_rb][rd_addr];
    if (wacc) begin
      m_st[m_wb] = wr_last ? FULL : FILLING;
      if (wr_last) m_wb = 1 - m_wb;
    end
    if (racc) begin
      m_st[m_rb] = rd_last ? EMPTY : DRAINING;
      if (rd_last) m_rb = 1 - m_rb;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return AW'($urandom_range(990, 1023));
    if (r == 1) return AW'($urandom_range(0, 1023));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int wr_pct, rd_pct;
    checks = 0;
    failures = 0;
    wr_req = 1'b0; wr_last = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_last = 1'b0; rd_addr = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      check_outputs();
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      // Alternate balanced, read-starved and write-starved phases to hit both-full/both-empty.
      case ((cyc / 250) % 3)
        0:       begin wr_pct = 70; rd_pct = 70; end
        1:       begin wr_pct = 80; rd_pct = 10; end
        default: begin wr_pct = 10; rd_pct = 80; end
      endcase
      wr_req  = $urandom_range(0, 99) < wr_pct;
      wr_last = $urandom_range(0, 3) == 0;
      wr_addr = pick_addr();
      wr_data = {$urandom, $urandom};
      rd_req  = $urandom_range(0, 99) < rd_pct;
      rd_last = $urandom_range(0, 3) == 0;
      rd_addr = pick_addr();
      model_step();
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
